alu_cmd_queue: RTL and testbench

Command buffer and result tracker that sits directly upstream of the sequential ALU. It accepts ALU commands (A, B, opcode) over a valid/ready handshake and holds them in a DEPTH-entry FIFO. It issues one command per cycle into the ALU's operand/opcode inputs and tracks each issued command through the ALU's fixed latency, so that the ALU Result leaves the block tagged and qualified by out_valid.

---
 rtl/alu_cmd_queue.sv | 212 +++++++++++++++++++++
 tb/tb_alu_cmd_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue
// Command buffer and result tracker placed directly upstream of the sequential
// ALU. Commands {A, B, opcode} are accepted over a valid/ready handshake into a
// DEPTH-entry FIFO, issued one per cycle into registered ALU operand/opcode
// outputs, and followed through the ALU's fixed latency so the ALU Result leaves
// the block qualified by out_valid and tagged with a wrapping sequence number.
//
// Ports:
//    clk, rst                 clock, asynchronous active-high reset
//    in_valid / in_ready      command handshake (in_ready = !full)
//    in_A, in_B, in_opcode    command payload
//    stall                    blocks issue this cycle
//    flush                    synchronously discards all queued commands
//    alu_A, alu_B, alu_opcode registered operands/opcode driven into the ALU
//    alu_issue                high the cycle after a command was loaded
//    alu_Result               Result returned by the ALU
//    out_valid, out_result,   completing command: result (pass-through),
//    out_tag, out_opcode      sequence tag and opcode
//    count, full, empty       FIFO status, decoded from registered state only
//
// Optional feature (macro ALU_CMDQ_STATS_EN): adds saturating 16-bit counters
//    issue_cnt (issues performed) and stall_cnt (cycles with !empty && stall).

module alu_cmd_queue #(
   parameter int DATA_W  = 8,
   parameter int OP_W    = 4,
   parameter int RES_W   = 16,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1,
   parameter int TAG_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_A,
   input  logic [DATA_W-1:0]        in_B,
   input  logic [OP_W-1:0]          in_opcode,
   input  logic                     stall,
   input  logic                     flush,
   output logic [DATA_W-1:0]        alu_A,
   output logic [DATA_W-1:0]        alu_B,
   output logic [OP_W-1:0]          alu_opcode,
   output logic                     alu_issue,
   input  logic [RES_W-1:0]         alu_Result,
   output logic                     out_valid,
   output logic [RES_W-1:0]         out_result,
   output logic [TAG_W-1:0]         out_tag,
   output logic [OP_W-1:0]          out_opcode,
`ifdef ALU_CMDQ_STATS_EN
   output logic [15:0]              issue_cnt,
   output logic [15:0]              stall_cnt,
`endif
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] memA_q  [DEPTH];
   logic [DATA_W-1:0] memB_q  [DEPTH];
   logic [OP_W-1:0]   memOp_q [DEPTH];

   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [TAG_W-1:0]  tagCnt_q, tagCnt_d;

   logic [DATA_W-1:0] aluA_q, aluB_q;
   logic [OP_W-1:0]   aluOp_q;
   logic [TAG_W-1:0]  aluTag_q;
   logic              aluIssue_q;

   logic              trkValid_q [ALU_LAT];
   logic [TAG_W-1:0]  trkTag_q   [ALU_LAT];
   logic [OP_W-1:0]   trkOp_q    [ALU_LAT];

   logic              pushEn;
   logic              issueEn;

   // Status flags come straight from the registered count, so in_ready never
   // depends combinationally on in_valid.
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign count    = count_q;

   // Flush wins over both push and issue. Issue is decided from the pre-edge
   // state, so an entry pushed into an empty queue can only issue next edge.
   always_comb begin
      pushEn   = in_valid && !full && !flush;
      issueEn  = !empty && !stall && !flush;
      wrPtr_d  = wrPtr_q;
      rdPtr_d  = rdPtr_q;
      count_d  = count_q;
      tagCnt_d = tagCnt_q;
      if (issueEn) begin
         tagCnt_d = tagCnt_q + TAG_W'(1);
      end
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
         end
         if (issueEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         if (pushEn && !issueEn) begin
            count_d = count_q + CNT_W'(1);
         end else if (issueEn && !pushEn) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // FIFO storage carries no reset; only entries between the pointers are
   // ever read.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         memA_q[wrPtr_q]  <= in_A;
         memB_q[wrPtr_q]  <= in_B;
         memOp_q[wrPtr_q] <= in_opcode;
      end
   end

   // Queue bookkeeping plus the ALU-facing registers. The tag travels with the
   // loaded command so the tracker sees the value the counter had at issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         tagCnt_q   <= '0;
         aluA_q     <= '0;
         aluB_q     <= '0;
         aluOp_q    <= '0;
         aluTag_q   <= '0;
         aluIssue_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         tagCnt_q   <= tagCnt_d;
         aluIssue_q <= issueEn;
         if (issueEn) begin
            aluA_q   <= memA_q[rdPtr_q];
            aluB_q   <= memB_q[rdPtr_q];
            aluOp_q  <= memOp_q[rdPtr_q];
            aluTag_q <= tagCnt_q;
         end
      end
   end

   // Tracking pipeline mirrors the ALU latency; its last stage lines up with
   // the cycle in which alu_Result belongs to that command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ALU_LAT; i++) begin
            trkValid_q[i] <= 1'b0;
            trkTag_q[i]   <= '0;
            trkOp_q[i]    <= '0;
         end
      end else begin
         trkValid_q[0] <= aluIssue_q;
         trkTag_q[0]   <= aluTag_q;
         trkOp_q[0]    <= aluOp_q;
         for (int i = 1; i < ALU_LAT; i++) begin
            trkValid_q[i] <= trkValid_q[i-1];
            trkTag_q[i]   <= trkTag_q[i-1];
            trkOp_q[i]    <= trkOp_q[i-1];
         end
      end
   end

   assign alu_A      = aluA_q;
   assign alu_B      = aluB_q;
   assign alu_opcode = aluOp_q;
   assign alu_issue  = aluIssue_q;
   assign out_valid  = trkValid_q[ALU_LAT-1];
   assign out_tag    = trkTag_q[ALU_LAT-1];
   assign out_opcode = trkOp_q[ALU_LAT-1];
   assign out_result = alu_Result;

`ifdef ALU_CMDQ_STATS_EN
   logic [15:0] issueCnt_q;
   logic [15:0] stallCnt_q;

   // Saturating activity counters; flush deliberately leaves them alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issueCnt_q <= '0;
         stallCnt_q <= '0;
      end else begin
         if (issueEn && (issueCnt_q != 16'hFFFF)) begin
            issueCnt_q <= issueCnt_q + 16'd1;
         end
         if (!empty && stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
         end
      end
   end

   assign issue_cnt = issueCnt_q;
   assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue
// Randomized and directed stimulus for alu_cmd_queue. A queue-level reference
// model decides each edge which command is accepted and which is issued, and
// pushes the expected completion (tag, opcode, result, edge) onto a scoreboard.
// A monitor on the falling edge pops that scoreboard whenever out_valid shows,
// and also compares the FIFO status against the model's occupancy.

module tb_alu_cmd_queue;

   localparam int DATA_W  = 8;
   localparam int OP_W    = 4;
   localparam int RES_W   = 16;
   localparam int DEPTH   = 4;
   localparam int ALU_LAT = 1;
   localparam int TAG_W   = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_A, in_B;
   logic [OP_W-1:0]   in_opcode;
   logic              stall, flush;
   logic [DATA_W-1:0] alu_A, alu_B;
   logic [OP_W-1:0]   alu_opcode;
   logic              alu_issue;
   logic [RES_W-1:0]  alu_Result;
   logic              out_valid;
   logic [RES_W-1:0]  out_result;
   logic [TAG_W-1:0]  out_tag;
   logic [OP_W-1:0]   out_opcode;
   logic [$clog2(DEPTH):0] count;
   logic              full, empty;
`ifdef ALU_CMDQ_STATS_EN
   logic [15:0]       issue_cnt, stall_cnt;
`endif

   alu_cmd_queue #(
      .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W),
      .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_A(in_A), .in_B(in_B), .in_opcode(in_opcode),
      .stall(stall), .flush(flush),
      .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
      .alu_issue(alu_issue), .alu_Result(alu_Result),
      .out_valid(out_valid), .out_result(out_result),
      .out_tag(out_tag), .out_opcode(out_opcode),
`ifdef ALU_CMDQ_STATS_EN
      .issue_cnt(issue_cnt), .stall_cnt(stall_cnt),
`endif
      .count(count), .full(full), .empty(empty)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
   } cmd_t;

   typedef struct {
      int          tag;
      logic [3:0]  op;
      logic [15:0] res;
      int          due;
   } exp_t;

   cmd_t modelQ[$];
   exp_t expQ[$];
   int   modelTag   = 0;
   int   cyc        = 0;
   int   testsRun   = 0;
   int   testsFailed = 0;

   // Arbitrary but opcode-dependent ALU function, so a swapped opcode or
   // operand shows up in the result.
   function automatic logic [15:0] aluFn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
      case (op[1:0])
         2'd0:    return {8'h00, a} + {8'h00, b};
         2'd1:    return {8'h00, a} * {8'h00, b};
         2'd2:    return {a, b};
         default: return {8'h00, a ^ b};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the sequential ALU: one cycle from operand load to Result.
   logic [RES_W-1:0] aluResReg;
   always @(posedge clk or posedge rst) begin
      if (rst) aluResReg <= '0;
      else if (alu_issue) aluResReg <= aluFn(alu_A, alu_B, alu_opcode);
   end
   assign alu_Result = aluResReg;

   // Reference model: occupancy decides acceptance, a pending command issues
   // unless stalled or flushed, and a flush discards everything still queued.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            modelQ.delete();
            expQ.delete();
            modelTag = 0;
         end else begin
            bit   doIssue;
            bit   doPush;
            cmd_t c;
            exp_t e;
            doIssue = (modelQ.size() > 0) && !stall && !flush;
            doPush  = in_valid && (modelQ.size() < DEPTH) && !flush;
            if (flush) begin
               modelQ.delete();
            end else begin
               if (doIssue) begin
                  c = modelQ.pop_front();
                  e.tag = modelTag;
                  e.op  = c.op;
                  e.res = aluFn(c.a, c.b, c.op);
                  e.due = cyc + ALU_LAT;
                  expQ.push_back(e);
                  modelTag = (modelTag + 1) % (1 << TAG_W);
               end
               if (doPush) begin
                  c.a  = in_A;
                  c.b  = in_B;
                  c.op = in_opcode;
                  modelQ.push_back(c);
               end
            end
         end
      end
   end

   // Monitor: status against model occupancy, completions against scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_t e;
            checkOutput("count", 32'(count), 32'(modelQ.size()));
            checkOutput("in_ready", 32'(in_ready), 32'(modelQ.size() < DEPTH));
            checkOutput("full", 32'(full), 32'(modelQ.size() == DEPTH));
            checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
            if (out_valid) begin
               if (expQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL spurious_out_valid: got out_valid=1 tag=%0d, expected no completion (t=%0t)",
                           out_tag, $time);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("out_edge", 32'(cyc), 32'(e.due));
                  checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
                  checkOutput("out_opcode", 32'(out_opcode), 32'(e.op));
                  checkOutput("out_result", 32'(out_result), 32'(e.res));
               end
            end else begin
               while (expQ.size() > 0 && expQ[0].due <= cyc) begin
                  e = expQ.pop_front();
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL missing_out_valid: got out_valid=0 at edge %0d, expected tag %0d",
                           cyc, e.tag);
               end
            end
         end
      end
   end

   // Drives one cycle of inputs, starting just after an edge.
   task automatic applyStimulus(input bit v, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] op, input bit st, input bit fl);
      in_valid  = v;
      in_A      = a;
      in_B      = b;
      in_opcode = op;
      stall     = st;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_alu_issue", 32'(alu_issue), 32'd0);
      checkOutput("rst_alu_A", 32'(alu_A), 32'd0);
      checkOutput("rst_alu_B", 32'(alu_B), 32'd0);
      checkOutput("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_CMDQ_STATS_EN
      checkOutput("rst_issue_cnt", 32'(issue_cnt), 32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
   endtask

   // Raises reset between edges, checks the immediate effect, then releases.
   task automatic doReset();
      #2;
      rst = 1'b1;
      #1;
      checkResetValues();
      modelQ.delete();
      expQ.delete();
      modelTag = 0;
      in_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      int waitCycles;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_A      = '0;
      in_B      = '0;
      in_opcode = '0;
      stall     = 1'b0;
      flush     = 1'b0;
      @(posedge clk);
      #1;
      checkResetValues();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single command straight after reset.
      applyStimulus(1'b1, 8'h12, 8'h34, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
      checkOutput("single_alu_A", 32'(alu_A), 32'h12);
      checkOutput("single_alu_B", 32'(alu_B), 32'h34);
      checkOutput("single_alu_issue", 32'(alu_issue), 32'd1);
      idle(4);

      // Fill while stalled; the fifth command waits until space opens.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(i + 1), 8'(i + 16), 4'(i), 1'b1, 1'b0);
      end
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 8'h05, 8'h15, 4'h5, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h05, 8'h15, 4'h5, 1'b1, 1'b0);
      checkOutput("fill_held_count", 32'(count), 32'd4);
      applyStimulus(1'b1, 8'h05, 8'h15, 4'h5, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h05, 8'h15, 4'h5, 1'b0, 1'b0);
      idle(8);

      // Push and issue on the same edge at count 2.
      doReset();
      applyStimulus(1'b1, 8'd1, 8'h40, 4'h1, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'd2, 8'h41, 4'h2, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'd3, 8'h42, 4'h3, 1'b0, 1'b0);
      checkOutput("push_issue_count", 32'(count), 32'd2);
      idle(6);

      // Flush with three queued and one in flight.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(8'h21 + i), 8'h07, 4'(i + 4), 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h99, 8'h99, 4'h9, 1'b0, 1'b1);
      checkOutput("flush_count", 32'(count), 32'd0);
      checkOutput("flush_empty", 32'(empty), 32'd1);
      applyStimulus(1'b1, 8'h55, 8'h66, 4'h2, 1'b0, 1'b0);
      idle(6);

      // Seventeen back-to-back commands run the tag through its wrap.
      doReset();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      end
      idle(6);

      // Asynchronous reset with two queued and one in flight.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'(8'h70 + i), 8'h03, 4'h1, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
      doReset();
      idle(5);

      // Random traffic with occasional stalls and flushes.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 29) == 0));
      end

      // Drain with a bounded wait.
      waitCycles = 0;
      while ((modelQ.size() > 0 || expQ.size() > 0) && waitCycles < 40) begin
         applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
         waitCycles++;
      end
      idle(2);
      if (expQ.size() != 0 || modelQ.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain_timeout: got %0d completions still pending, expected 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
